data_memory_system: RTL and testbench

//  Data-side memory slave that sits directly downstream of the core's data memory stage.
//  It serves the mem_d_* port: a byte-maskable word RAM plus an MMIO window.
//  The MMIO window holds a GPIO register, a free-running cycle counter and an 8N1 UART transmitter.
//  The core registers the read data at the DM/WB boundary, so reads are combinational and writes commit on the clock edge.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/data_memory_system_uart_tx.sv | 103 ++++++++++
 rtl/data_memory_system.sv | 99 +++++++++
 tb/tb_data_memory_system.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-side memory slave.
// Holds the MMIO window decode constants and the UART transmitter state encoding.
package dmem_pkg;

    localparam int MMIO_BASE_BIT = 31;

    localparam logic [3:0] OFF_GPIO      = 4'h0;
    localparam logic [3:0] OFF_UART_DATA = 4'h4;
    localparam logic [3:0] OFF_UART_STAT = 4'h8;
    localparam logic [3:0] OFF_CYCLE     = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/data_memory_system_uart_tx.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, one stop bit.
// A start request is honoured only in IDLE; requests while a frame is in flight are dropped.
module uart_tx
    import dmem_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             bit_done;

    assign bit_done = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (start) begin
                    data_d  = data;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = DATA;
                    tx_d    = data_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                tx_d = data_q[idx_q];
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered alongside the state so the line changes exactly on bit boundaries
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: rtl/data_memory_system.sv
// Data-side memory slave: byte-maskable word RAM plus an MMIO window holding
// GPIO, a free-running cycle counter and a UART transmitter. Reads are combinational.
module data_memory_system
    import dmem_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter     INIT_FILE    = "",
    parameter int CLKS_PER_BIT = 868,
    parameter int GPIO_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_d_we,
    input  logic [3:0]        mem_d_wmask,
    input  logic [31:0]       mem_d_a,
    input  logic [31:0]       mem_d_wd,
    output logic [31:0]       mem_d_rd,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              uart_tx
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]       ram [DEPTH];
    logic [AW-1:0]     word_idx;
    logic [3:0]        offset;
    logic              is_mmio;
    logic              ram_we;
    logic              mmio_we;
    logic [GPIO_W-1:0] gpio_q;
    logic [31:0]       cycle_q;
    logic              uart_start;
    logic              uart_busy;
    logic              unused_addr_bits;

    assign word_idx = mem_d_a[AW+1:2];
    assign offset   = mem_d_a[3:0];
    assign is_mmio  = mem_d_a[MMIO_BASE_BIT];
    assign ram_we   = mem_d_we && !is_mmio;
    assign mmio_we  = mem_d_we && is_mmio && (|mem_d_wmask);

    // Upper RAM address bits alias onto the same words and are deliberately ignored
    assign unused_addr_bits = ^mem_d_a[30:AW+2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && mem_d_wmask[i]) begin
                ram[word_idx][8*i +: 8] <= mem_d_wd[8*i +: 8];
            end
        end
    end

    // Register writes use the full word; lane masks only gate whether the write happens
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q  <= '0;
            cycle_q <= '0;
        end else begin
            if (mmio_we && offset == OFF_GPIO) begin
                gpio_q <= mem_d_wd[GPIO_W-1:0];
            end
            if (mmio_we && offset == OFF_CYCLE) begin
                cycle_q <= mem_d_wd;
            end else begin
                cycle_q <= cycle_q + 32'd1;
            end
        end
    end

    assign uart_start = mmio_we && (offset == OFF_UART_DATA);

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .reset(reset),
        .start(uart_start),
        .data (mem_d_wd[7:0]),
        .tx   (uart_tx),
        .busy (uart_busy)
    );

    always_comb begin
        mem_d_rd = '0;
        if (!is_mmio) begin
            mem_d_rd = ram[word_idx];
        end else begin
            case (offset)
                OFF_GPIO:      mem_d_rd = 32'(gpio_q);
                OFF_UART_STAT: mem_d_rd = {31'b0, uart_busy};
                OFF_CYCLE:     mem_d_rd = cycle_q;
                default:       mem_d_rd = '0;
            endcase
        end
    end

    assign gpio_out = gpio_q;

endmodule

// File: tb/tb_data_memory_system.sv
// Bench for data_memory_system: RAM/MMIO vector table plus hand-written
// cycle-counter and UART frame sequences, all checked through a scoreboard queue.
module tb_data_memory_system;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_d_we;
    logic [3:0]  mem_d_wmask;
    logic [31:0] mem_d_a;
    logic [31:0] mem_d_wd;
    logic [31:0] mem_d_rd;
    logic [7:0]  gpio_out;
    logic        uart_tx;

    always #5 clk = ~clk;

    data_memory_system #(
        .DEPTH       (1024),
        .INIT_FILE   (""),
        .CLKS_PER_BIT(4),
        .GPIO_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_d_we   (mem_d_we),
        .mem_d_wmask(mem_d_wmask),
        .mem_d_a    (mem_d_a),
        .mem_d_wd   (mem_d_wd),
        .mem_d_rd   (mem_d_rd),
        .gpio_out   (gpio_out),
        .uart_tx    (uart_tx)
    );

    localparam logic [31:0] A_GPIO = 32'h8000_0000;
    localparam logic [31:0] A_UDAT = 32'h8000_0004;
    localparam logic [31:0] A_STAT = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_000C;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  mask;
        logic [31:0] rd_a;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[15];

    function automatic void expect_val(string name, logic [31:0] exp);
        sb_q.push_back('{name, exp});
    endfunction

    function automatic void compare(logic [31:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h with no expected value queued", act);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endfunction

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        mem_d_we    = 1'b0;
        mem_d_wmask = 4'h0;
        mem_d_a     = a;
        expect_val(name, exp);
        #1;
        compare(mem_d_rd);
    endtask

    task automatic pin_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        expect_val(name, exp);
        compare(act);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] mask);
        @(negedge clk);
        mem_d_we    = 1'b1;
        mem_d_a     = a;
        mem_d_wd    = wd;
        mem_d_wmask = mask;
        @(posedge clk);
        #1;
        mem_d_we    = 1'b0;
        mem_d_wmask = 4'h0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        int b;
        b = k / 4;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    initial begin
        vecs[0]  = '{"ram_full",      1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF};
        vecs[1]  = '{"ram_lane2",     1'b1, 32'h0000_0010, 32'h00AA_0000, 4'h4, 32'h0000_0010, 32'hDEAA_BEEF};
        vecs[2]  = '{"ram_byteaddr",  1'b0, 32'h0,         32'h0,         4'h0, 32'h0000_0012, 32'hDEAA_BEEF};
        vecs[3]  = '{"ram_highalias", 1'b0, 32'h0,         32'h0,         4'h0, 32'h7FFF_F010, 32'hDEAA_BEEF};
        vecs[4]  = '{"ram_wrap",      1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0000_0000, 32'h1234_5678};
        vecs[5]  = '{"ram_mask0",     1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 32'h1234_5678};
        vecs[6]  = '{"ram_word1",     1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'hF, 32'h0000_0004, 32'hCAFE_F00D};
        vecs[7]  = '{"ram_lane0",     1'b1, 32'h0000_0007, 32'h0000_00EE, 4'h1, 32'h0000_0004, 32'hCAFE_F0EE};
        vecs[8]  = '{"gpio_wr",       1'b1, A_GPIO,        32'h0000_01A5, 4'hF, A_GPIO,        32'h0000_00A5};
        vecs[9]  = '{"gpio_mask0",    1'b1, A_GPIO,        32'h0000_005A, 4'h0, A_GPIO,        32'h0000_00A5};
        vecs[10] = '{"unmapped_rd",   1'b0, 32'h0,         32'h0,         4'h0, 32'h8000_0006, 32'h0};
        vecs[11] = '{"unmapped_wr",   1'b1, 32'h8000_0001, 32'h0000_00FF, 4'hF, A_GPIO,        32'h0000_00A5};
        vecs[12] = '{"mmio_alias",    1'b0, 32'h0,         32'h0,         4'h0, 32'hFFFF_FFF0, 32'h0000_00A5};
        vecs[13] = '{"status_wr",     1'b1, A_STAT,        32'hFFFF_FFFF, 4'hF, A_STAT,        32'h0};
        vecs[14] = '{"uartdata_rd",   1'b0, 32'h0,         32'h0,         4'h0, A_UDAT,        32'h0};

        reset       = 1'b1;
        mem_d_we    = 1'b0;
        mem_d_wmask = 4'h0;
        mem_d_a     = 32'h0;
        mem_d_wd    = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        pin_chk("rst_gpio", 32'(gpio_out), 32'h0);
        pin_chk("rst_tx", {31'b0, uart_tx}, 32'h1);
        read_chk("rst_busy", A_STAT, 32'h0);
        read_chk("rst_cycle", A_CYC, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].we) do_write(vecs[i].a, vecs[i].wd, vecs[i].mask);
            read_chk(vecs[i].name, vecs[i].rd_a, vecs[i].exp);
        end
        pin_chk("gpio_pins", 32'(gpio_out), 32'h0000_00A5);

        // Read in the same cycle as a write sees the old word
        @(negedge clk);
        mem_d_we    = 1'b1;
        mem_d_a     = 32'h0000_0010;
        mem_d_wd    = 32'h1111_1111;
        mem_d_wmask = 4'hF;
        expect_val("rd_during_wr", 32'hDEAA_BEEF);
        #1;
        compare(mem_d_rd);
        @(posedge clk);
        #1;
        read_chk("rd_after_wr", 32'h0000_0010, 32'h1111_1111);

        pulse_reset();
        pin_chk("rst2_gpio", 32'(gpio_out), 32'h0);
        tick(5);
        read_chk("cycle_5", A_CYC, 32'd5);
        do_write(A_CYC, 32'hFFFF_FFFE, 4'hF);
        read_chk("cycle_load", A_CYC, 32'hFFFF_FFFE);
        tick(1);
        read_chk("cycle_max", A_CYC, 32'hFFFF_FFFF);
        tick(1);
        read_chk("cycle_wrap", A_CYC, 32'h0);

        pulse_reset();
        do_write(A_UDAT, 32'h0000_0055, 4'h1);
        for (int k = 0; k < 40; k++) begin
            pin_chk($sformatf("tx55_k%0d", k), {31'b0, uart_tx}, {31'b0, frame_bit(8'h55, k)});
            if (k == 0 || k == 39) read_chk($sformatf("busy_k%0d", k), A_STAT, 32'h1);
            if (k == 2) begin
                mem_d_we    = 1'b1;
                mem_d_a     = A_UDAT;
                mem_d_wd    = 32'h0000_00FF;
                mem_d_wmask = 4'hF;
            end else begin
                mem_d_we    = 1'b0;
                mem_d_wmask = 4'h0;
            end
            @(posedge clk);
            #1;
        end
        pin_chk("tx_idle_end", {31'b0, uart_tx}, 32'h1);
        read_chk("busy_end", A_STAT, 32'h0);

        // Write in the first IDLE cycle after STOP starts a new frame
        do_write(A_UDAT, 32'h0000_00A3, 4'hF);
        read_chk("b2b_busy", A_STAT, 32'h1);
        pin_chk("b2b_start", {31'b0, uart_tx}, 32'h0);
        tick(5);
        pin_chk("a3_bit0", {31'b0, uart_tx}, 32'h1);
        tick(8);
        pin_chk("a3_bit2", {31'b0, uart_tx}, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        pin_chk("abort_tx", {31'b0, uart_tx}, 32'h1);
        read_chk("abort_busy", A_STAT, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick(4);
            pin_chk($sformatf("post_abort_tx%0d", j), {31'b0, uart_tx}, 32'h1);
        end
        read_chk("post_abort_busy", A_STAT, 32'h0);

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
